dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters:
//  - m0: the CPU load/store path.
//  - m1: the debug/UART program loader.
//  Sequences each access (grant, memory enable, read-latency wait, read-data return) through a small FSM.
//  Sits between the MemOrIO address/data path and DMem; it is the only driver of DMem's enable, write and address inputs.
// PARAMETERS
//  ADDR_W   14  word-address width driven to DMem
//  DATA_W   32  data width
//  MEM_LAT  1   DMem read latency in cycles (legal 1..4): mem_rdata is valid MEM_LAT cycles after the mem_en cycle
// PORTS
//  clk        in   1       system clock; every register updates on posedge
//  rst        in   1       synchronous, active-high reset
//  m0_req     in   1       CPU access request; hold with m0_we/addr/wdata stable until m0_gnt
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  CPU word address
//  m0_wdata   in   DATA_W  CPU write data
//  m0_gnt     out  1       one-cycle pulse: m0 access issued to DMem
//  m0_rvalid  out  1       one-cycle pulse: m0_rdata valid
//  m0_rdata   out  DATA_W  CPU read data
//  m1_*       -    -       loader port; same set and semantics as m0_*
//  mem_en     out  1       DMem enable
//  mem_we     out  1       DMem write enable
//  mem_addr   out  ADDR_W  DMem address
//  mem_wdata  out  DATA_W  DMem write data
//  mem_rdata  in   DATA_W  DMem read data
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset (sync, active-high) forces:
//    - state = IDLE;
//    - gnt, rvalid, mem_en, mem_we, busy = 0;
//    - mem_addr, mem_wdata, rdata = 0;
//    - last_gnt = 1, so m0 wins the first tie.
//  - FSM states: IDLE, GRANT, RDWAIT, RESP.
//  - IDLE:
//    - req sampled. If any req is high, the winner's we/addr/wdata are latched and the FSM goes to GRANT.
//    - In GRANT: winner gnt=1, mem_en=1, mem_we=we (exactly one cycle).
//  - GRANT:
//    - write -> IDLE; mem_en falls. A write costs 2 cycles, req to next sample.
//    - read -> RDWAIT with cnt = MEM_LAT-1; mem_en falls.
//  - RDWAIT:
//    - while cnt != 0: decrement.
//    - at cnt == 0: capture mem_rdata into the winner's rdata and go to RESP.
//    - With MEM_LAT = 1, the capture happens in the cycle right after GRANT.
//  - RESP: winner rvalid=1 for one cycle, rdata held -> IDLE.
//    - Read latency from the gnt cycle to the rvalid cycle is MEM_LAT+1.
//    - rdata holds its value until the next read for that port.
//  - req is ignored outside IDLE.
//    - A requester drops req the cycle after gnt; a req still high when the FSM is back in IDLE is a new access.
//  - Arbitration (both req high in IDLE): round-robin.
//    - The port not equal to last_gnt wins; last_gnt updates on every grant.
//    - A single requester is always granted, regardless of last_gnt.
//  - Never both gnt in one cycle, and never two outstanding accesses.
//  - Reset mid-access (GRANT/RDWAIT/RESP):
//    - the access is abandoned: no rvalid and no further mem_en;
//    - a write already presented in GRANT is not undone.
//  - The addr/wdata latch at IDLE decouples DMem from requester changes after the grant.
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN
//    - defined: m0 (CPU) wins every tie. m1 is served only in IDLE cycles where m0_req = 0; last_gnt is still maintained but unused.
//    - undefined (default): round-robin as above.
// TESTING
//  1. Reset, m0 write addr=0x010 data=0xDEADBEEF:
//     m0_gnt 1 cycle after req sampled, with mem_en=1 and mem_we=1 in that cycle; busy=0 the next cycle.
//  2. m0 read addr=0x010 (MEM_LAT=1):
//     m0_rvalid 2 cycles after m0_gnt, with m0_rdata=0xDEADBEEF; m1 outputs stay 0.
//  3. m0_req and m1_req held high together for 4 accesses (writes):
//     grants m0, m1, m0, m1. With DMEM_ARB_FIXED_PRIO_EN, all go to m0 while m0_req stays high.
//  4. MEM_LAT=3, m1 read:
//     rvalid exactly 4 cycles after m1_gnt; busy high from the gnt cycle through the rvalid cycle.
//  5. rst asserted in the RDWAIT cycle of a read:
//     no rvalid ever; the next cycle shows state IDLE and all outputs 0. The next tie is granted to m0.
//  6. m1_req raised while an m0 read is in RDWAIT:
//     m1 is not granted until the cycle after m0's RESP (GRANT issued at IDLE+1).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU (m0) and
// the debug/UART loader (m1), sequencing grant, enable, read wait and response.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN gives m0 priority on every tie
// (default build arbitrates ties round-robin).
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, GRANT, RDWAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sel, sel_nxt;
  logic              op_we, op_we_nxt;
  logic              last_gnt, last_gnt_nxt;
  logic              pick;

  logic              m0_gnt_nxt, m1_gnt_nxt;
  logic              m0_rvalid_nxt, m1_rvalid_nxt;
  logic [DATA_W-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic              mem_en_nxt, mem_we_nxt, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  // Winner of an IDLE-cycle request (0 = m0, 1 = m1)
  always_comb begin
    pick = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick = ~m0_req;
`else
    if (m0_req && m1_req) begin
      pick = ~last_gnt;
    end else begin
      pick = m1_req;
    end
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    sel_nxt       = sel;
    op_we_nxt     = op_we;
    last_gnt_nxt  = last_gnt;
    m0_gnt_nxt    = 1'b0;
    m1_gnt_nxt    = 1'b0;
    m0_rvalid_nxt = 1'b0;
    m1_rvalid_nxt = 1'b0;
    m0_rdata_nxt  = m0_rdata;
    m1_rdata_nxt  = m1_rdata;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    busy_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt     = GRANT;
          sel_nxt       = pick;
          last_gnt_nxt  = pick;
          op_we_nxt     = pick ? m1_we : m0_we;
          mem_addr_nxt  = pick ? m1_addr : m0_addr;
          mem_wdata_nxt = pick ? m1_wdata : m0_wdata;
          m0_gnt_nxt    = ~pick;
          m1_gnt_nxt    = pick;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = op_we_nxt;
        end
      end
      GRANT: begin
        if (op_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RDWAIT;
          cnt_nxt   = CNT_W'(MEM_LAT - 1);
        end
      end
      RDWAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = RESP;
          if (sel) begin
            m1_rdata_nxt  = mem_rdata;
            m1_rvalid_nxt = 1'b1;
          end else begin
            m0_rdata_nxt  = mem_rdata;
            m0_rvalid_nxt = 1'b1;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      op_we     <= 1'b0;
      last_gnt  <= 1'b1;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      op_we     <= op_we_nxt;
      last_gnt  <= last_gnt_nxt;
      m0_gnt    <= m0_gnt_nxt;
      m1_gnt    <= m1_gnt_nxt;
      m0_rvalid <= m0_rvalid_nxt;
      m1_rvalid <= m1_rvalid_nxt;
      m0_rdata  <= m0_rdata_nxt;
      m1_rdata  <= m1_rdata_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed traffic from both requesters, with a
// transaction-level model predicting grants, read returns and busy per cycle.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 3;
  localparam int          TIMEOUT = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle number of the current clock period
  always @(posedge clk) cyc <= cyc + 1;

  // Simple DMem: writes on the enable edge, read data MEM_LAT cycles later, noise otherwise
  logic [DATA_W-1:0] dmem  [0:31];
  logic [DATA_W-1:0] rpipe [0:MEM_LAT-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) dmem[mem_addr[4:0]] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? dmem[mem_addr[4:0]] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[MEM_LAT-1];

  typedef struct {
    int                cyc;
    bit                port;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } gnt_t;

  typedef struct {
    int                cyc;
    bit                port;
    logic [DATA_W-1:0] data;
  } rv_t;

  gnt_t exp_g[$];
  rv_t  exp_r[$];

  logic [DATA_W-1:0] ref_mem [0:31];
  logic [DATA_W-1:0] hold    [0:1];
  bit                m_last = 1'b1;
  int                next_sample = 0;
  int                busy_from = 0;
  int                busy_till = -1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: decides each access when the arbiter is next free to sample
  always @(negedge clk) begin
    bit   w;
    gnt_t g;
    rv_t  r;
    #1;
    if (rst) begin
      exp_g.delete();
      exp_r.delete();
      m_last      = 1'b1;
      next_sample = cyc + 1;
      if (busy_till > cyc) busy_till = cyc;
    end else if (cyc == next_sample) begin
      if (m0_req || m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w = !m0_req;
`else
        if (m0_req && m1_req) w = (m_last == 1'b0);
        else                  w = m1_req;
`endif
        m_last = w;
        g.cyc  = cyc + 1;
        g.port = w;
        g.we   = w ? m1_we : m0_we;
        g.addr = w ? m1_addr : m0_addr;
        g.data = w ? m1_wdata : m0_wdata;
        exp_g.push_back(g);
        busy_from = cyc + 1;
        if (g.we) begin
          ref_mem[g.addr[4:0]] = g.data;
          busy_till   = cyc + 1;
          next_sample = cyc + 2;
        end else begin
          r.cyc  = cyc + 2 + MEM_LAT;
          r.port = w;
          r.data = ref_mem[g.addr[4:0]];
          exp_r.push_back(r);
          busy_till   = cyc + 2 + MEM_LAT;
          next_sample = cyc + 3 + MEM_LAT;
        end
      end else begin
        next_sample = cyc + 1;
      end
    end
  end

  // Monitor: compares every DUT output against what the model has queued for this cycle
  always @(negedge clk) begin
    bit   ga, ra;
    gnt_t g;
    rv_t  r;
    if (cyc >= 1) begin
      ga = (exp_g.size() != 0) && (exp_g[0].cyc == cyc);
      ra = (exp_r.size() != 0) && (exp_r[0].cyc == cyc);
      chk("m0_gnt", 64'(m0_gnt), 64'(ga && !exp_g[0].port));
      chk("m1_gnt", 64'(m1_gnt), 64'(ga && exp_g[0].port));
      chk("mem_en", 64'(mem_en), 64'(ga));
      if (ga) begin
        g = exp_g.pop_front();
        chk("mem_we", 64'(mem_we), 64'(g.we));
        chk("mem_addr", 64'(mem_addr), 64'(g.addr));
        if (g.we) chk("mem_wdata", 64'(mem_wdata), 64'(g.data));
      end else begin
        chk("mem_we_idle", 64'(mem_we), 64'(0));
      end
      chk("m0_rvalid", 64'(m0_rvalid), 64'(ra && !exp_r[0].port));
      chk("m1_rvalid", 64'(m1_rvalid), 64'(ra && exp_r[0].port));
      if (ra) begin
        r = exp_r.pop_front();
        hold[r.port] = r.data;
      end
      chk("m0_rdata", 64'(m0_rdata), 64'(hold[0]));
      chk("m1_rdata", 64'(m1_rdata), 64'(hold[1]));
      chk("busy", 64'(busy), 64'((cyc >= busy_from) && (cyc <= busy_till)));
    end
    if (rst) begin
      hold[0] = '0;
      hold[1] = '0;
    end
  end

  // One access from port p: hold request until granted, then drop it
  task automatic do_req(input bit p, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    bit got = 1'b0;
    if (p) begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    while (!got && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      got = p ? m1_gnt : m0_gnt;
    end
    chk(p ? "m1_gnt_wait_bound" : "m0_gnt_wait_bound", 64'(got), 64'(1));
    @(posedge clk);
    #1;
    if (p) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we, busy}), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_m0_rdata"}, 64'(m0_rdata), 64'(0));
    chk({tag, "_m1_rdata"}, 64'(m1_rdata), 64'(0));
  endtask

  task automatic traffic(input bit p, input int count);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_req(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = '0;
      dmem[i]    = '0;
    end
    hold[0] = '0;
    hold[1] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    // Write then read back on m0
    do_req(1'b0, 1'b1, ADDR_W'(16), 32'hDEADBEEF);
    do_req(1'b0, 1'b0, ADDR_W'(16), 32'h0);
    repeat (MEM_LAT + 4) @(posedge clk);
    #1;

    // Both ports contending for back-to-back writes
    fork
      begin for (int i = 0; i < 2; i++) do_req(1'b0, 1'b1, ADDR_W'(i), 32'h1000 + 32'(i)); end
      begin for (int i = 0; i < 2; i++) do_req(1'b1, 1'b1, ADDR_W'(i + 4), 32'h2000 + 32'(i)); end
    join
    repeat (4) @(posedge clk);
    #1;

    // m1 read exercising the full latency
    do_req(1'b1, 1'b0, ADDR_W'(16), 32'h0);
    repeat (MEM_LAT + 4) @(posedge clk);
    #1;

    // Reset during the first read-wait cycle abandons the read
    do_req(1'b0, 1'b0, ADDR_W'(4), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    repeat (MEM_LAT + 2) @(negedge clk);
    chk("no_rvalid_after_reset", 64'({m0_rvalid, m1_rvalid}), 64'(0));
    @(posedge clk);
    #1;
    fork
      do_req(1'b0, 1'b1, ADDR_W'(8), 32'hA5A5_0000);
      do_req(1'b1, 1'b1, ADDR_W'(9), 32'h5A5A_0000);
    join
    repeat (4) @(posedge clk);
    #1;

    // m1 request arriving while an m0 read is waiting
    fork
      do_req(1'b0, 1'b0, ADDR_W'(5), 32'h0);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_req(1'b1, 1'b1, ADDR_W'(5), 32'hCAFE_F00D);
      end
    join
    repeat (MEM_LAT + 4) @(posedge clk);
    #1;

    // Random concurrent traffic
    fork
      traffic(1'b0, 40);
      traffic(1'b1, 40);
    join

    repeat (MEM_LAT + 8) @(posedge clk);
    #1;
    chk("queues_drained", 64'(exp_g.size() + exp_r.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
